cbus_uncached_bridge: RTL and testbench

- Initiator side of the cbus protocol: arbitrates the core's ibus and dbus requests onto a single cbus port, feeding the cbus memory responder in the simulation top.
- Each request becomes one single-beat cbus transaction (len 0, burst FIXED).
- Completion is returned to the core as an addr_ok/data_ok pulse.
- Sits between the core and the memory model; no caching, no buffering beyond one in-flight request.

---
 rtl/cbus_uncached_bridge_pkg.sv | 65 ++++++
 rtl/cbus_uncached_bridge_arbiter2.sv | 36 +++
 rtl/cbus_uncached_bridge.sv | 114 +++++++++++
 tb/tb_cbus_uncached_bridge.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_uncached_bridge_pkg.sv
// Shared cbus/core bus types for the uncached bridge: transfer sizes, burst
// encodings, request/response structs and the two-way grant identifier.
package cbus_uncached_bridge_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } bridge_grant_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_uncached_bridge_arbiter2.sv
// Two-requester arbiter: combinational grant, round-robin or dbus-priority,
// with the last-grant register advanced only when a transaction completes.
module cbus_arbiter2
    import cbus_uncached_bridge_pkg::*;
#(
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_i_i,
    input  logic          req_d_i,
    input  logic          update_i,
    input  bridge_grant_t update_grant_i,
    output bridge_grant_t grant_o
);

    bridge_grant_t last_grant_q;

    always_comb begin
        grant_o = GRANT_D;
        if (req_i_i && !req_d_i) begin
            grant_o = GRANT_I;
        end else if (req_i_i && req_d_i && (ROUND_ROBIN != 0) && (last_grant_q == GRANT_D)) begin
            grant_o = GRANT_I;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_q <= GRANT_D;
        end else if (update_i) begin
            last_grant_q <= update_grant_i;
        end
    end

endmodule

// File: rtl/cbus_uncached_bridge.sv
// Uncached ibus/dbus to cbus bridge: one single-beat transaction in flight,
// completion returned combinationally as an addr_ok/data_ok pulse.
module cbus_uncached_bridge
    import cbus_uncached_bridge_pkg::*;
#(
    parameter int unsigned ROUND_ROBIN = 1,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned TCNT_W      = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp,
    output logic       timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q;
    cbus_req_t         req_q;
    bridge_grant_t     grant_q;
    bridge_grant_t     arb_grant;
    logic [TCNT_W-1:0] cnt_q;
    logic              timeout_q;
    logic              complete;

    // Gating with reset keeps a completion from escaping during an abort.
    assign complete = (state_q == BUSY) && oresp.ready && oresp.last && reset;

    cbus_arbiter2 #(
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_arb (
        .clk            (clk),
        .reset          (reset),
        .req_i_i        (ireq.valid),
        .req_d_i        (dreq.valid),
        .update_i       (complete),
        .update_grant_i (grant_q),
        .grant_o        (arb_grant)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            grant_q   <= GRANT_D;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ireq.valid || dreq.valid) begin
                        state_q     <= BUSY;
                        grant_q     <= arb_grant;
                        cnt_q       <= '0;
                        req_q.valid <= 1'b1;
                        req_q.len   <= '0;
                        req_q.burst <= AXI_BURST_FIXED;
                        if (arb_grant == GRANT_D) begin
                            req_q.addr     <= dreq.addr;
                            req_q.size     <= dreq.size;
                            req_q.is_write <= (dreq.strobe != '0);
                            req_q.strobe   <= dreq.strobe;
                            req_q.data     <= dreq.data;
                        end else begin
                            req_q.addr     <= ireq.addr;
                            req_q.size     <= MSIZE4;
                            req_q.is_write <= 1'b0;
                            req_q.strobe   <= '0;
                            req_q.data     <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (cnt_q == TCNT_W'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                    end
                    if (complete) begin
                        state_q     <= IDLE;
                        req_q.valid <= 1'b0;
                        cnt_q       <= '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        iresp = '0;
        dresp = '0;
        if (complete) begin
            if (grant_q == GRANT_D) begin
                dresp.addr_ok = 1'b1;
                dresp.data_ok = 1'b1;
                dresp.data    = oresp.data;
            end else begin
                iresp.addr_ok = 1'b1;
                iresp.data_ok = 1'b1;
                iresp.data    = req_q.addr[2] ? oresp.data[63:32] : oresp.data[31:0];
            end
        end
    end

    assign oreq    = req_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_cbus_uncached_bridge.sv
// Directed bench: round-robin bridge (a) and fixed-priority, short-timeout bridge (b).
module tb_cbus_uncached_bridge;
    import cbus_uncached_bridge_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq_a, ireq_b;
    ibus_resp_t iresp_a, iresp_b;
    dbus_req_t  dreq_a, dreq_b;
    dbus_resp_t dresp_a, dresp_b;
    cbus_req_t  oreq_a, oreq_b;
    cbus_resp_t oresp_a, oresp_b;
    logic       timeout_a, timeout_b;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    cbus_uncached_bridge #(.ROUND_ROBIN(1), .TIMEOUT(1024), .TCNT_W(11)) u_rr (
        .clk(clk), .reset(reset), .ireq(ireq_a), .iresp(iresp_a), .dreq(dreq_a),
        .dresp(dresp_a), .oreq(oreq_a), .oresp(oresp_a), .timeout(timeout_a)
    );

    cbus_uncached_bridge #(.ROUND_ROBIN(0), .TIMEOUT(16), .TCNT_W(5)) u_fp (
        .clk(clk), .reset(reset), .ireq(ireq_b), .iresp(iresp_b), .dreq(dreq_b),
        .dresp(dresp_b), .oreq(oreq_b), .oresp(oresp_b), .timeout(timeout_b)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic cbus_req_t cur_req(input bit sel);
        return sel ? oreq_b : oreq_a;
    endfunction

    function automatic ibus_resp_t cur_iresp(input bit sel);
        return sel ? iresp_b : iresp_a;
    endfunction

    function automatic dbus_resp_t cur_dresp(input bit sel);
        return sel ? dresp_b : dresp_a;
    endfunction

    task automatic set_resp(input bit sel, input logic rdy, input logic lst, input logic [63:0] d);
        cbus_resp_t r;
        r = '{ready: rdy, last: lst, data: d};
        if (sel) oresp_b = r;
        else     oresp_a = r;
    endtask

    // Waits for a request, holds it for lat wait cycles, completes it and
    // verifies the bridge returns to IDLE with no lingering response.
    task automatic serve(input bit sel, input int unsigned lat, input logic [63:0] rdata,
                         output cbus_req_t seen, output bit igot, output bit dgot,
                         output logic [31:0] idata, output logic [63:0] ddata);
        bit found;
        ibus_resp_t ir;
        dbus_resp_t dr;
        found = 1'b0; igot = 1'b0; dgot = 1'b0; idata = '0; ddata = '0; seen = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); #1;
            if (cur_req(sel).valid) found = 1'b1;
        end
        check("valid_wait", 128'(found), 128'(1));
        if (!found) return;
        seen = cur_req(sel);
        for (int unsigned i = 0; i < lat; i++) begin
            set_resp(sel, 1'b0, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
            #1;
            ir = cur_iresp(sel); dr = cur_dresp(sel);
            check("hold_stable", 128'(cur_req(sel)), 128'(seen));
            check("early_ok", 128'({ir.addr_ok, ir.data_ok, dr.addr_ok, dr.data_ok}), 128'(0));
            @(negedge clk); #1;
        end
        set_resp(sel, 1'b1, 1'b1, rdata);
        #1;
        ir = cur_iresp(sel); dr = cur_dresp(sel);
        check("final_stable", 128'(cur_req(sel)), 128'(seen));
        igot  = ir.addr_ok && ir.data_ok;
        dgot  = dr.addr_ok && dr.data_ok;
        idata = ir.data;
        ddata = dr.data;
        @(negedge clk); #1;
        set_resp(sel, 1'b0, 1'b0, 64'h0);
        #1;
        ir = cur_iresp(sel); dr = cur_dresp(sel);
        check("idle_valid", 128'(cur_req(sel).valid), 128'(0));
        check("after_ok", 128'({ir.addr_ok, ir.data_ok, dr.addr_ok, dr.data_ok}), 128'(0));
    endtask

    initial begin
        cbus_req_t   seen;
        bit          ig, dg, found;
        logic [31:0] id;
        logic [63:0] dd;

        reset   = 1'b0;
        ireq_a  = '0; ireq_b = '0; dreq_a = '0; dreq_b = '0;
        oresp_a = '0; oresp_b = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_oreq_a", 128'(oreq_a), 128'(0));
        check("rst_resp_a", 128'({iresp_a, dresp_a}), 128'(0));
        check("rst_to_a", 128'(timeout_a), 128'(0));
        check("rst_oreq_b", 128'(oreq_b), 128'(0));
        check("rst_resp_b", 128'({iresp_b, dresp_b}), 128'(0));
        check("rst_to_b", 128'(timeout_b), 128'(0));
        reset = 1'b1;

        // Single dbus read
        dreq_a = '{valid: 1'b1, addr: 32'h8000_0010, size: MSIZE8, strobe: 8'h00, data: 64'h0};
        serve(1'b0, 5, 64'h1122_3344_5566_7788, seen, ig, dg, id, dd);
        dreq_a.valid = 1'b0;
        check("rd_dgot", 128'(dg), 128'(1));
        check("rd_igot", 128'(ig), 128'(0));
        check("rd_data", 128'(dd), 128'(64'h1122_3344_5566_7788));
        check("rd_wr", 128'(seen.is_write), 128'(0));
        check("rd_len", 128'(seen.len), 128'(0));
        check("rd_burst", 128'(seen.burst), 128'(AXI_BURST_FIXED));
        check("rd_addr", 128'(seen.addr), 128'(32'h8000_0010));
        check("rd_size", 128'(seen.size), 128'(MSIZE8));

        // ibus fetch, high word
        ireq_a = '{valid: 1'b1, addr: 32'h8000_0004};
        serve(1'b0, 6, 64'hAAAA_BBBB_CCCC_DDDD, seen, ig, dg, id, dd);
        ireq_a.valid = 1'b0;
        check("if_igot", 128'(ig), 128'(1));
        check("if_dgot", 128'(dg), 128'(0));
        check("if_data_hi", 128'(id), 128'(32'hAAAA_BBBB));
        check("if_size", 128'(seen.size), 128'(MSIZE4));
        check("if_wr", 128'({seen.is_write, seen.strobe}), 128'(0));

        // ibus fetch, low word, long responder latency
        ireq_a = '{valid: 1'b1, addr: 32'h8000_0008};
        serve(1'b0, 131, 64'hAAAA_BBBB_CCCC_DDDD, seen, ig, dg, id, dd);
        ireq_a.valid = 1'b0;
        check("if_data_lo", 128'(id), 128'(32'hCCCC_DDDD));
        check("if_long_igot", 128'(ig), 128'(1));

        // dbus write
        dreq_a = '{valid: 1'b1, addr: 32'h4060_0004, size: MSIZE4, strobe: 8'hF0,
                   data: 64'h0000_0041_0000_0000};
        serve(1'b0, 4, 64'h0, seen, ig, dg, id, dd);
        dreq_a.valid = 1'b0;
        check("wr_wr", 128'(seen.is_write), 128'(1));
        check("wr_strobe", 128'(seen.strobe), 128'(8'hF0));
        check("wr_data", 128'(seen.data), 128'(64'h0000_0041_0000_0000));
        check("wr_addr", 128'(seen.addr), 128'(32'h4060_0004));
        check("wr_dgot", 128'(dg), 128'(1));

        // Round robin after reset: I, D, I, D
        reset = 1'b0;
        @(negedge clk); #1;
        reset  = 1'b1;
        ireq_a = '{valid: 1'b1, addr: 32'h8000_0000};
        dreq_a = '{valid: 1'b1, addr: 32'h8000_0100, size: MSIZE8, strobe: 8'h00, data: 64'h0};
        for (int k = 0; k < 4; k++) begin
            serve(1'b0, 2, 64'h0102_0304_0506_0708, seen, ig, dg, id, dd);
            check("rr_igot", 128'(ig), 128'((k % 2) == 0));
            check("rr_dgot", 128'(dg), 128'((k % 2) == 1));
            check("rr_addr", 128'(seen.addr), 128'(((k % 2) == 0) ? 32'h8000_0000 : 32'h8000_0100));
        end
        ireq_a.valid = 1'b0;
        dreq_a.valid = 1'b0;

        // Fixed priority: dbus wins whenever pending
        ireq_b = '{valid: 1'b1, addr: 32'h8000_0004};
        dreq_b = '{valid: 1'b1, addr: 32'h8000_0200, size: MSIZE8, strobe: 8'h00, data: 64'h0};
        for (int k = 0; k < 3; k++) begin
            serve(1'b1, 3, 64'h5555_6666_7777_8888, seen, ig, dg, id, dd);
            check("fp_dgot", 128'(dg), 128'(1));
            check("fp_igot", 128'(ig), 128'(0));
        end
        dreq_b.valid = 1'b0;
        serve(1'b1, 3, 64'h5555_6666_7777_8888, seen, ig, dg, id, dd);
        ireq_b.valid = 1'b0;
        check("fp_ionly", 128'(ig), 128'(1));
        check("fp_idata", 128'(id), 128'(32'h5555_6666));
        check("fp_no_to", 128'(timeout_b), 128'(0));

        // Timeout with TIMEOUT=16 and a silent responder
        dreq_b = '{valid: 1'b1, addr: 32'h0000_1000, size: MSIZE8, strobe: 8'h00, data: 64'h0};
        @(negedge clk); #1;
        check("to_busy", 128'(oreq_b.valid), 128'(1));
        repeat (15) @(negedge clk);
        #1;
        check("to_before", 128'(timeout_b), 128'(0));
        @(negedge clk); #1;
        check("to_set", 128'(timeout_b), 128'(1));
        repeat (40) @(negedge clk);
        #1;
        check("to_hold", 128'(timeout_b), 128'(1));
        check("to_still_busy", 128'(oreq_b.valid), 128'(1));
        set_resp(1'b1, 1'b1, 1'b1, 64'h9);
        #1;
        check("to_late_ok", 128'(dresp_b.data_ok), 128'(1));
        @(negedge clk); #1;
        set_resp(1'b1, 1'b0, 1'b0, 64'h0);
        dreq_b.valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("to_sticky", 128'(timeout_b), 128'(1));

        // Reset mid-transaction aborts without a completion pulse
        dreq_a = '{valid: 1'b1, addr: 32'h8000_0300, size: MSIZE8, strobe: 8'h00, data: 64'h0};
        found  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); #1;
            if (oreq_a.valid) found = 1'b1;
        end
        check("ab_busy", 128'(found), 128'(1));
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        set_resp(1'b0, 1'b1, 1'b1, 64'h77);
        #1;
        check("ab_no_ok", 128'({dresp_a.addr_ok, dresp_a.data_ok}), 128'(0));
        @(negedge clk); #1;
        check("ab_valid", 128'(oreq_a.valid), 128'(0));
        check("ab_oreq_zero", 128'(oreq_a), 128'(0));
        check("ab_no_ok2", 128'({dresp_a.addr_ok, dresp_a.data_ok}), 128'(0));
        check("ab_to_clear", 128'(timeout_b), 128'(0));
        reset = 1'b1;
        dreq_a.valid = 1'b0;
        set_resp(1'b0, 1'b0, 1'b0, 64'h0);
        repeat (2) @(negedge clk);
        #1;
        check("ab_stay_idle", 128'(oreq_a.valid), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
